// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: sequences the PLL reset, waits for lock with a timeout,
// qualifies lock as stable before raising ready, and tracks retries,
// lock losses and a sticky failure after too many failed attempts.
module pll_lock_ctrl #(
  parameter int RstCycles    = 16,
  parameter int LockTimeout  = 65536,
  parameter int StableCycles = 1024,
  parameter int MaxRetries   = 7,
  parameter int SyncStages   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int MaxAB  = (RstCycles > LockTimeout) ? RstCycles : LockTimeout;
  localparam int MaxCyc = (MaxAB > StableCycles) ? MaxAB : StableCycles;
  localparam int CntW   = $clog2(MaxCyc) + 1;

  localparam logic [CntW-1:0] RstLast    = CntW'(RstCycles - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LockTimeout - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(StableCycles - 1);
  localparam logic [3:0]      RetryMax   = 4'(MaxRetries);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_READY  = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [3:0]            retry_q, retry_d;
  logic [7:0]            loss_q, loss_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  ready_q, ready_d;
  logic                  fail_q, fail_d;
  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  lock_s;
  logic                  attempt_fail;

  assign lock_s = sync_q[SyncStages-1];

  // Lock synchronizer shift chain; oldest stage feeds the FSM.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], pll_lock};
  end

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    loss_d       = loss_q;
    attempt_fail = 1'b0;

    case (state_q)
      S_RST:    if (cnt_q == RstLast) state_d = S_WAIT;
      S_WAIT: begin
        if (lock_s)                     state_d = S_STABLE;
        else if (cnt_q == TimeoutLast)  attempt_fail = 1'b1;
      end
      S_STABLE: begin
        if (!lock_s)                    attempt_fail = 1'b1;
        else if (cnt_q == StableLast)   state_d = S_READY;
      end
      S_READY: begin
        if (!lock_s) begin
          state_d = S_RST;
          retry_d = 4'd0;
          if (loss_q != 8'hff) loss_d = loss_q + 8'd1;
        end
      end
      S_FAIL:   state_d = S_FAIL;
      default:  state_d = S_RST;
    endcase

    // Timeout and lock glitch share one failure path.
    if (attempt_fail) begin
      if (retry_q == RetryMax) begin
        state_d = S_FAIL;
      end else begin
        retry_d = retry_q + 4'd1;
        state_d = S_RST;
      end
    end

    // restart overrides everything, and suppresses any increment this cycle.
    if (restart) begin
      state_d = S_RST;
      retry_d = 4'd0;
      loss_d  = loss_q;
    end

    // Shared counter: cleared on any state change, only runs in timed states.
    if (restart || (state_d != state_q))
      cnt_d = '0;
    else if (state_q == S_RST || state_q == S_WAIT || state_q == S_STABLE)
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = '0;

    pll_rst_d = (state_d == S_RST) || (state_d == S_FAIL);
    ready_d   = (state_d == S_READY);
    fail_d    = (state_d == S_FAIL);
  end

  // State and output registers, async active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RST;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      loss_q    <= 8'd0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      sync_q    <= sync_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Randomized + directed bench for pll_lock_ctrl against a phase/deadline model.
module tb_pll_lock_ctrl;
  localparam int RC = 4, TO = 64, SC = 8, MR = 2, SS = 2;

  logic       clk, rst, pll_lock, restart;
  logic       pll_rst, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  pll_lock_ctrl #(
    .RstCycles(RC), .LockTimeout(TO), .StableCycles(SC),
    .MaxRetries(MR), .SyncStages(SS)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .restart(restart),
    .pll_rst(pll_rst), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_pass;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at t=%0t", tag, obs, exp, $time);
  endtask

  // Reference model: phase name plus absolute edge index of phase entry.
  localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_READY = 3, P_FAIL = 4;
  int m_phase, m_entry, m_cyc, m_retry, m_loss;
  int m_dly[SS];

  function automatic void model_reset();
    m_phase = P_RST; m_entry = 0; m_cyc = 0; m_retry = 0; m_loss = 0;
    for (int i = 0; i < SS; i++) m_dly[i] = 0;
  endfunction

  function automatic void enter(input int p);
    m_phase = p;
    m_entry = m_cyc;
  endfunction

  function automatic void attempt_failed();
    if (m_retry == MR) enter(P_FAIL);
    else begin m_retry++; enter(P_RST); end
  endfunction

  function automatic void model_step(input int lk, input int rs);
    int ls, n;
    ls = m_dly[SS-1];
    for (int i = SS-1; i > 0; i--) m_dly[i] = m_dly[i-1];
    m_dly[0] = lk;
    m_cyc++;
    n = m_cyc - m_entry;   // edges seen since entering the phase
    if (rs != 0) begin
      m_retry = 0;
      enter(P_RST);
    end else begin
      case (m_phase)
        P_RST:    if (n == RC) enter(P_WAIT);
        P_WAIT:   if (ls != 0) enter(P_STABLE); else if (n == TO) attempt_failed();
        P_STABLE: if (ls == 0) attempt_failed(); else if (n == SC) enter(P_READY);
        P_READY:  if (ls == 0) begin
                    if (m_loss < 255) m_loss++;
                    m_retry = 0;
                    enter(P_RST);
                  end
        default: ;
      endcase
    end
  endfunction

  task automatic compare_all();
    chk("pll_rst",   int'(pll_rst),   (m_phase == P_RST || m_phase == P_FAIL) ? 1 : 0);
    chk("ready",     int'(ready),     (m_phase == P_READY) ? 1 : 0);
    chk("fail",      int'(fail),      (m_phase == P_FAIL) ? 1 : 0);
    chk("retry_cnt", int'(retry_cnt), m_retry);
    chk("loss_cnt",  int'(loss_cnt),  m_loss);
  endtask

  // Called at a negedge: check, drive, take one edge, advance model.
  task automatic step_cycle(input logic lk, input logic rs);
    compare_all();
    pll_lock = lk;
    restart  = rs;
    @(posedge clk);
    model_step(int'(lk), int'(rs));
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic lk);
    for (int i = 0; i < n; i++) step_cycle(lk, 1'b0);
  endtask

  initial begin
    logic lk;
    int   rate;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; pll_lock = 1'b0; restart = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all();                         // reset values
    rst = 1'b0;

    // 1: lock 20 cycles after pll_rst falls, then hold
    run(RC + 20, 1'b0);
    run(30, 1'b1);
    chk("s1_ready", int'(ready), 1);

    // 3: lock loss from READY for 3 cycles
    run(3, 1'b0);
    run(25, 1'b1);
    chk("s3_loss", int'(loss_cnt), 1);
    chk("s3_ready", int'(ready), 1);

    // 4: glitch in STABLE at count 5
    step_cycle(1'b1, 1'b1);
    run(8, 1'b1);
    run(1, 1'b0);
    run(8, 1'b1);
    chk("s4_retry", int'(retry_cnt), 1);
    run(20, 1'b1);

    // 2: never lock -> FAIL after three attempts
    step_cycle(1'b0, 1'b1);
    run(203, 1'b0);
    chk("s2_fail_pre", int'(fail), 0);
    run(1, 1'b0);
    chk("s2_fail", int'(fail), 1);
    run(20, 1'b1);                         // lock ignored in FAIL
    chk("s2_hold", int'(pll_rst), 1);

    // 5: restart from FAIL, one timeout, then restart on the next timeout edge
    step_cycle(1'b0, 1'b1);
    chk("s5_fail_clr", int'(fail), 0);
    run(RC + TO, 1'b0);
    run(RC + TO - 1, 1'b0);
    chk("s5_retry1", int'(retry_cnt), 1);
    step_cycle(1'b0, 1'b1);
    chk("s5_restart_win", int'(retry_cnt), 0);
    run(30, 1'b1);
    chk("s5_ready", int'(ready), 1);

    // random: lock with varying flip rates, occasional restart
    lk = 1'b1;
    for (int b = 0; b < 60; b++) begin
      case ($urandom_range(0, 2))
        0: rate = 4;
        1: rate = 20;
        default: rate = 100;
      endcase
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(0, rate - 1) == 0) lk = ~lk;
        step_cycle(lk, ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
      end
    end

    // 6: saturate loss_cnt
    step_cycle(1'b1, 1'b1);
    run(20, 1'b1);
    for (int e = 0; e < 260; e++) begin
      run(3, 1'b0);
      run(20, 1'b1);
    end
    chk("s6_loss_sat", int'(loss_cnt), 255);
    chk("s6_ready", int'(ready), 1);

    // async rst mid-READY: outputs change with no clock edge
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready",   int'(ready),    0);
    chk("arst_pll_rst", int'(pll_rst),  1);
    chk("arst_loss",    int'(loss_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run(RC + 2, 1'b1);
    run(20, 1'b1);
    chk("post_rst_ready", int'(ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
